// File: rtl/rr_control_merge.sv
// N-to-1 control merge: grants one valid input, drives data and index channels eagerly,
// holds the grant until both accept. Define RR_CONTROL_MERGE_ROUND_ROBIN_EN for round-robin, else fixed priority.
module rr_control_merge #(
    parameter  int SIZE        = 2,
    parameter  int DATA_TYPE   = 32,
    localparam int INDEX_WIDTH = ($clog2(SIZE) > 1) ? $clog2(SIZE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE*DATA_TYPE-1:0] ins,
    input  logic [SIZE-1:0]           ins_valid,
    output logic [SIZE-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]      outs,
    output logic                      outs_valid,
    input  logic                      outs_ready,
    output logic [INDEX_WIDTH-1:0]    index,
    output logic                      index_valid,
    input  logic                      index_ready
);
    logic [SIZE-1:0][DATA_TYPE-1:0] ins_arr;
    logic                           locked, done_o, done_i;
    logic [INDEX_WIDTH-1:0]         lock_idx, start, arb_sel, sel;
    logic                           sel_valid, complete;

    assign ins_arr = ins;

`ifdef RR_CONTROL_MERGE_ROUND_ROBIN_EN
    logic [INDEX_WIDTH-1:0] ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (complete)
            ptr <= (sel == INDEX_WIDTH'(SIZE - 1)) ? '0 : sel + 1'b1;
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    // Second pass overrides the first: lowest valid at/above start wins, else lowest below it.
    always_comb begin
        arb_sel = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (ins_valid[i] && (INDEX_WIDTH'(i) < start)) arb_sel = INDEX_WIDTH'(i);
        for (int i = SIZE - 1; i >= 0; i--)
            if (ins_valid[i] && (INDEX_WIDTH'(i) >= start)) arb_sel = INDEX_WIDTH'(i);
    end

    assign sel       = locked ? lock_idx : arb_sel;
    assign sel_valid = locked ? ins_valid[lock_idx] : |ins_valid;
    assign complete  = rst & sel_valid & (done_o | outs_ready) & (done_i | index_ready);

    assign outs_valid  = rst & sel_valid & ~done_o;
    assign index_valid = rst & sel_valid & ~done_i;
    assign outs        = rst ? ins_arr[sel] : '0;
    assign index       = rst ? sel : '0;

    for (genvar g = 0; g < SIZE; g++) begin : g_ready
        assign ins_ready[g] = complete & (sel == INDEX_WIDTH'(g));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            done_o   <= 1'b0;
            done_i   <= 1'b0;
        end else if (complete) begin
            locked <= 1'b0;
            done_o <= 1'b0;
            done_i <= 1'b0;
        end else if (sel_valid) begin
            locked   <= 1'b1;
            lock_idx <= sel;
            done_o   <= done_o | (outs_valid & outs_ready);
            done_i   <= done_i | (index_valid & index_ready);
        end
    end
endmodule

// File: doc/rr_control_merge.md
Name: rr_control_merge

Overview:
- N-to-1 control merge, the collecting counterpart of the fork family: it gathers SIZE input channels into one data output channel and one index output channel.
- Arbitrates among valid inputs and locks the grant until both output channels have accepted the token.
- Drives the two output channels eagerly, each with its own done flag.
- Sits at dataflow join points such as loop headers and if/else reconvergence, feeding downstream muxes with the winning index.

Parameters:
- SIZE, 2: number of input channels (>=2).
- DATA_TYPE, 32: data width per channel.
- INDEX_WIDTH, derived localparam = max(1, $clog2(SIZE)): width of the index output.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- ins  input  SIZE*DATA_TYPE  packed input data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_valid  input  SIZE  per-input valid.
- ins_ready  output  SIZE  per-input ready; one-hot or zero.
- outs  output  DATA_TYPE  data of the granted input.
- outs_valid  output  1  data channel valid.
- outs_ready  input  1  data channel ready.
- index  output  INDEX_WIDTH  number of the granted input.
- index_valid  output  1  index channel valid.
- index_ready  input  1  index channel ready.

Behaviour:
- State registers:
  - locked (1b) and lock_idx (INDEX_WIDTH): grant lock.
  - done_o and done_i (1b each): the data and index channels have already transferred.
  - ptr (INDEX_WIDTH): round-robin start point.
  - All reset to 0.
- While rst=0:
  - ins_ready, outs_valid and index_valid are forced to 0.
  - outs and index are don't-care; drive 0.
- Selection, combinational:
  - If locked, sel = lock_idx and sel_valid = ins_valid[lock_idx].
  - Otherwise sel = first i with ins_valid[i]=1, searching from ptr upward with wrap (SIZE-1 -> 0), and sel_valid = |ins_valid.
- Outputs:
  - outs = ins[sel].
  - index = sel.
  - outs_valid = sel_valid & ~done_o.
  - index_valid = sel_valid & ~done_i.
  - Zero latency: input valid in cycle t can appear at the outputs in cycle t.
- complete = sel_valid & (done_o | outs_ready) & (done_i | index_ready).
- ins_ready[sel] = complete; every other ins_ready bit is 0.
- On a clock edge with complete = 1:
  - done_o, done_i and locked are cleared.
  - ptr updates to (sel+1) mod SIZE.
- On a clock edge with sel_valid = 1 and complete = 0:
  - locked <= 1 and lock_idx <= sel.
  - done_o |= outs_valid & outs_ready.
  - done_i |= index_valid & index_ready.
- With sel_valid = 0, state holds.
- Lock guarantee: no re-arbitration mid-transaction. A higher-priority input becoming valid while locked is ignored until completion.
- Producers must hold valid until ready (standard protocol). Dropping ins_valid[lock_idx] while locked is illegal; the block holds state and does not recover.
- Both outputs ready in the same cycle: completes in one cycle; the done flags never set.
- Consecutive tokens: after a completion, a new grant can be presented in the very next cycle. Sustained throughput is 1 token/cycle when both outputs are ready.
- SIZE not a power of 2: the wrap search covers indices 0..SIZE-1 only.
- Reset asserted mid-transaction: state clears immediately (async). The partially consumed token is not acknowledged on the input side.

Optional Feature:
- Macro RR_CONTROL_MERGE_ROUND_ROBIN_EN.
- Defined: round-robin arbitration starting from ptr, as above.
- Undefined: fixed priority, lowest valid index wins. The ptr register is removed (search start is constant 0). Lock and done behaviour are unchanged.

Test Plan (SIZE=3, DATA_TYPE=8, RR defined unless noted):
- Single token, both ready: ins_valid=3'b010, ins[15:8]=8'hA5, outs_ready=index_ready=1 -> same cycle outs=8'hA5, index=1, both valids=1, ins_ready=3'b010; ptr becomes 2.
- Split acceptance: ins_valid=3'b001, data 8'h3C, outs_ready=1, index_ready=0 for 2 cycles, then 1:
  - Cycle 0: data transfers, done_o=1.
  - Cycles 1-2: outs_valid=0, index_valid=1, ins_ready=0.
  - Cycle 2 (index_ready=1): ins_ready=3'b001; the token is consumed exactly once on each output.
- Lock hold: input 2 granted, outs_ready=0 for 3 cycles; input 0 raises valid in cycle 1 -> index stays 2 until completion; input 0 granted next cycle.
- Round-robin fairness: all ins_valid=3'b111 held, both readies=1 for 6 cycles -> index sequence 0,1,2,0,1,2. With the macro undefined -> 0,0,0,0,0,0.
- Async reset mid-transaction: done_o=1 and locked=1, pull rst=0 between clock edges -> outputs and ins_ready go 0 immediately. After rst=1, a held ins_valid=3'b100 is re-presented with done flags clear.
- Back-to-back with stall: tokens on inputs 1 and 2 with index_ready toggling 1,0,1 -> each token is delivered exactly once per output, and no ins_ready pulse occurs without both transfers.
